// File: rtl/mlaccel_cmd_sequencer_if.sv
// rtl/mlaccel_cmd_sequencer_if.sv - host byte stream, code-memory port and core control bundle
interface mlaccel_cmd_sequencer_if #(
  parameter int CODE_AW = 10
);
  logic               frm_start;
  logic               frm_end;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               tx_req;
  logic [7:0]         tx_data;
  logic               cmem_wen;
  logic               cmem_ren;
  logic [CODE_AW-1:0] cmem_addr;
  logic [31:0]        cmem_wdata;
  logic [31:0]        cmem_rdata;
  logic               core_start;
  logic [15:0]        core_addr;
  logic               core_busy;
  logic               core_err;
  logic               qpi_rdy;
  logic               qpi_err;

  modport master (
    input  frm_start, frm_end, rx_valid, rx_data, tx_req, cmem_rdata, core_busy, core_err,
    output tx_data, cmem_wen, cmem_ren, cmem_addr, cmem_wdata, core_start, core_addr,
           qpi_rdy, qpi_err
  );

  modport slave (
    output frm_start, frm_end, rx_valid, rx_data, tx_req, cmem_rdata, core_busy, core_err,
    input  tx_data, cmem_wen, cmem_ren, cmem_addr, cmem_wdata, core_start, core_addr,
           qpi_rdy, qpi_err
  );
endinterface

// File: rtl/mlaccel_cmd_sequencer.sv
// rtl/mlaccel_cmd_sequencer.sv - host command decoder, code-memory loader/reader and core launcher
module mlaccel_cmd_sequencer #(
  parameter int CODE_AW = 10
) (
  input  logic                    clock,
  input  logic                    resetn,
  mlaccel_cmd_sequencer_if.master bus
);
  localparam int         STATUS_W  = 8;
  localparam logic [7:0] OP_STATUS = 8'h20;
  localparam logic [7:0] OP_WRITE  = 8'h21;
  localparam logic [7:0] OP_READ   = 8'h23;
  localparam logic [7:0] OP_START  = 8'h25;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_STATUS, S_WRITE, S_RD_HDR, S_RD_DATA, S_ST_HDR, S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [1:0]         hcnt_q, hcnt_d;
  logic [31:0]        shreg_q, shreg_d;
  logic [CODE_AW-1:0] waddr_q, waddr_d;
  logic [CODE_AW-1:0] raddr_q, raddr_d;
  logic [7:0]         wleft_q, wleft_d;
  logic [31:0]        rword_q, rword_d;
  logic               rpend_q, rpend_d;
  logic               have_q, have_d;
  logic [1:0]         bsel_q, bsel_d;
  logic               core_start_q, core_start_d;
  logic [15:0]        core_addr_q, core_addr_d;
  logic               err_q, err_d;

  logic                byte_ok, avail, wen_c, ren_c, err_set, err_clr;
  logic [31:0]         cur_word;
  logic [15:0]         hdr_addr;
  logic [STATUS_W-1:0] status_byte;
  logic [7:0]          tx_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      hcnt_q       <= '0;
      shreg_q      <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      wleft_q      <= '0;
      rword_q      <= '0;
      rpend_q      <= 1'b0;
      have_q       <= 1'b0;
      bsel_q       <= '0;
      core_start_q <= 1'b0;
      core_addr_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      hcnt_q       <= hcnt_d;
      shreg_q      <= shreg_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      wleft_q      <= wleft_d;
      rword_q      <= rword_d;
      rpend_q      <= rpend_d;
      have_q       <= have_d;
      bsel_q       <= bsel_d;
      core_start_q <= core_start_d;
      core_addr_q  <= core_addr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    hcnt_d       = hcnt_q;
    shreg_d      = shreg_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    wleft_d      = wleft_q;
    rword_d      = rword_q;
    rpend_d      = ren_c;
    have_d       = have_q;
    bsel_d       = bsel_q;
    core_start_d = 1'b0;
    core_addr_d  = core_addr_q;
    err_set      = bus.core_err;
    err_clr      = 1'b0;

    // Read data arrives one cycle after the strobe; capture it for the remaining three bytes.
    if (rpend_q) begin
      rword_d = bus.cmem_rdata;
      have_d  = 1'b1;
    end

    if (bus.frm_end) begin
      state_d = S_IDLE;
    end else if (bus.frm_start) begin
      if (state_q != S_IDLE) err_set = 1'b1;
      state_d = S_CMD;
    end else begin
      case (state_q)
        S_CMD: begin
          if (bus.rx_valid) begin
            bcnt_d = '0;
            hcnt_d = '0;
            case (bus.rx_data)
              OP_STATUS: state_d = S_STATUS;
              OP_WRITE: begin
                state_d = S_WRITE;
                waddr_d = '0;
              end
              OP_READ: begin
                state_d = S_RD_HDR;
                have_d  = 1'b0;
                wleft_d = '0;
                bsel_d  = '0;
              end
              OP_START: state_d = S_ST_HDR;
              default: begin
                err_set = 1'b1;
                state_d = S_DRAIN;
              end
            endcase
          end
        end
        S_STATUS: begin
          if (bus.tx_req) begin
            bcnt_d = 2'd1;
            if (bcnt_q == 2'd0) err_clr = 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.rx_valid) begin
            shreg_d = {bus.rx_data, shreg_q[31:8]};
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) waddr_d = waddr_q + CODE_AW'(1);
          end
        end
        S_RD_HDR: begin
          if (bus.rx_valid) begin
            hcnt_d = hcnt_q + 2'd1;
            if (hcnt_q == 2'd0) begin
              shreg_d[7:0] = bus.rx_data;
            end else if (hcnt_q == 2'd1) begin
              raddr_d = hdr_addr[CODE_AW-1:0];
            end else begin
              state_d = S_RD_DATA;
              bsel_d  = '0;
              if (bus.rx_data != 8'h00) begin
                raddr_d = raddr_q + CODE_AW'(1);
                wleft_d = bus.rx_data - 8'd1;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (bus.tx_req && avail) begin
            bsel_d = bsel_q + 2'd1;
            if (bsel_q == 2'd3) begin
              if (wleft_q != 8'h00) begin
                raddr_d = raddr_q + CODE_AW'(1);
                wleft_d = wleft_q - 8'd1;
              end else begin
                have_d = 1'b0;
              end
            end
          end
        end
        S_ST_HDR: begin
          if (bus.rx_valid) begin
            if (hcnt_q == 2'd0) begin
              shreg_d[7:0] = bus.rx_data;
              hcnt_d       = 2'd1;
            end else begin
              state_d = S_DRAIN;
              if (bus.core_busy) begin
                err_set = 1'b1;
              end else begin
                core_start_d = 1'b1;
                core_addr_d  = hdr_addr;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // A fresh fault outranks the read-clear so it is never lost.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_comb begin
    byte_ok     = bus.rx_valid & ~bus.frm_end & ~bus.frm_start;
    avail       = rpend_q | have_q;
    cur_word    = rpend_q ? bus.cmem_rdata : rword_q;
    hdr_addr    = {bus.rx_data, shreg_q[7:0]};
    status_byte = {5'b0, err_q, bus.core_err, bus.core_busy};
    wen_c       = (state_q == S_WRITE) && byte_ok && (bcnt_q == 2'd3);
    // Next word is fetched on the last byte of the current one so a back-to-back request sees fresh data.
    ren_c       = ((state_q == S_RD_HDR) && byte_ok && (hcnt_q == 2'd2) && (bus.rx_data != 8'h00)) ||
                  ((state_q == S_RD_DATA) && bus.tx_req && !bus.frm_end && !bus.frm_start &&
                   avail && (bsel_q == 2'd3) && (wleft_q != 8'h00));
    tx_c        = 8'h00;
    case (state_q)
      S_STATUS:  tx_c = status_byte;
      S_RD_DATA: if (avail) tx_c = cur_word[8*bsel_q +: 8];
      default:   tx_c = 8'h00;
    endcase
  end

  assign bus.tx_data    = tx_c;
  assign bus.cmem_wen   = wen_c;
  assign bus.cmem_ren   = ren_c;
  assign bus.cmem_addr  = (state_q == S_WRITE) ? waddr_q : raddr_q;
  assign bus.cmem_wdata = wen_c ? {bus.rx_data, shreg_q[31:8]} : 32'h0;
  assign bus.core_start = core_start_q;
  assign bus.core_addr  = core_addr_q;
  assign bus.qpi_rdy    = (state_q == S_IDLE) & ~bus.core_busy & ~core_start_q;
  assign bus.qpi_err    = err_q;
endmodule

// File: tb/tb_mlaccel_cmd_sequencer.sv
// tb/tb_mlaccel_cmd_sequencer.sv - scoreboard bench for the host command sequencer
module tb_mlaccel_cmd_sequencer;
  localparam int CODE_AW = 10;
  localparam int DEPTH   = 1 << CODE_AW;

  typedef struct {
    logic [CODE_AW-1:0] addr;
    logic [31:0]        data;
  } wexp_t;

  typedef struct {
    int   kind;
    logic rdy;
    logic err;
  } probe_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  mlaccel_cmd_sequencer_if #(.CODE_AW(CODE_AW)) bus ();
  mlaccel_cmd_sequencer #(.CODE_AW(CODE_AW)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  wexp_t       wq[$];
  logic [7:0]  tq[$];
  logic [15:0] sq[$];
  probe_t      pq[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] tb_mem  [0:DEPTH-1];
  logic        err_m;
  bit          probe_req;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clock) begin
    if (bus.cmem_wen) tb_mem[bus.cmem_addr] <= bus.cmem_wdata;
    if (bus.cmem_ren) bus.cmem_rdata <= tb_mem[bus.cmem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    probe_t p;
    wexp_t  w;
    if (probe_req && pq.size() > 0) begin
      p = pq.pop_front();
      case (p.kind)
        1: begin
          chk("rst_tx_data",    32'(bus.tx_data),    32'h0);
          chk("rst_qpi_rdy",    32'(bus.qpi_rdy),    32'h1);
          chk("rst_qpi_err",    32'(bus.qpi_err),    32'h0);
          chk("rst_cmem_wen",   32'(bus.cmem_wen),   32'h0);
          chk("rst_cmem_ren",   32'(bus.cmem_ren),   32'h0);
          chk("rst_cmem_addr",  32'(bus.cmem_addr),  32'h0);
          chk("rst_cmem_wdata", bus.cmem_wdata,      32'h0);
          chk("rst_core_start", 32'(bus.core_start), 32'h0);
          chk("rst_core_addr",  32'(bus.core_addr),  32'h0);
        end
        2: begin
          chk("writes_missing", 32'(wq.size()), 32'h0);
          chk("tx_missing",     32'(tq.size()), 32'h0);
          chk("starts_missing", 32'(sq.size()), 32'h0);
        end
        default: begin
          chk("qpi_rdy", 32'(bus.qpi_rdy), 32'(p.rdy));
          chk("qpi_err", 32'(bus.qpi_err), 32'(p.err));
        end
      endcase
    end
    if (resetn) begin
      if (bus.cmem_wen) begin
        if (wq.size() == 0) chk("wen_unexpected", 32'(bus.cmem_wen), 32'h0);
        else begin
          w = wq.pop_front();
          chk("wen_addr", 32'(bus.cmem_addr), 32'(w.addr));
          chk("wen_data", bus.cmem_wdata, w.data);
        end
      end
      if (bus.cmem_wen || bus.cmem_ren) chk("wen_ren_excl", 32'(bus.cmem_wen & bus.cmem_ren), 32'h0);
      if (bus.tx_req) begin
        if (tq.size() == 0) chk("tx_unexpected", 32'(bus.tx_req), 32'h0);
        else chk("tx_data", 32'(bus.tx_data), 32'(tq.pop_front()));
      end
      if (bus.core_start) begin
        if (sq.size() == 0) chk("start_unexpected", 32'(bus.core_start), 32'h0);
        else chk("core_addr", 32'(bus.core_addr), 32'(sq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gap(input int maxg);
    repeat ($urandom_range(maxg, 0)) tick();
  endtask

  task automatic probe(input int kind, input logic rdy, input logic err);
    probe_t p;
    p.kind = kind;
    p.rdy  = rdy;
    p.err  = err;
    pq.push_back(p);
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  task automatic fstart();
    bus.frm_start = 1'b1;
    tick();
    bus.frm_start = 1'b0;
  endtask

  task automatic fend();
    bus.frm_end = 1'b1;
    tick();
    bus.frm_end = 1'b0;
    tick();
  endtask

  task automatic sbyte(input logic [7:0] b, input int maxg);
    gap(maxg);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic txr(input logic [7:0] e, input int maxg);
    gap(maxg);
    tq.push_back(e);
    bus.tx_req = 1'b1;
    tick();
    bus.tx_req = 1'b0;
  endtask

  task automatic do_write(input int n, input bit pattern, input int tail, input int maxg);
    logic [31:0] w;
    wexp_t       e;
    int          a;
    fstart();
    sbyte(8'h21, maxg);
    for (int i = 0; i < n; i++) begin
      w = pattern ? {15'd4, 11'(i), 6'd1} : $urandom;
      a = i % DEPTH;
      ref_mem[a] = w;
      for (int b = 0; b < 4; b++) begin
        if (b == 3) begin
          e.addr = CODE_AW'(a);
          e.data = w;
          wq.push_back(e);
        end
        sbyte(w[8*b +: 8], maxg);
      end
    end
    for (int t = 0; t < tail; t++) sbyte(8'($urandom), maxg);
    fend();
  endtask

  task automatic do_read(input logic [15:0] a16, input int cnt, input int extra, input int maxg);
    logic [31:0] w;
    int          a;
    fstart();
    sbyte(8'h23, maxg);
    sbyte(a16[7:0], maxg);
    sbyte(a16[15:8], maxg);
    sbyte(8'(cnt), maxg);
    a = int'(a16) % DEPTH;
    for (int i = 0; i < cnt; i++) begin
      w = ref_mem[(a + i) % DEPTH];
      for (int b = 0; b < 4; b++) txr(w[8*b +: 8], maxg);
    end
    for (int x = 0; x < extra; x++) txr(8'h00, maxg);
    fend();
  endtask

  task automatic status_body(input int n, input int maxg);
    for (int i = 0; i < n; i++) begin
      txr({5'b0, err_m, bus.core_err, bus.core_busy}, maxg);
      if (i == 0) err_m = bus.core_err;
    end
  endtask

  task automatic do_status(input int n);
    fstart();
    sbyte(8'h20, 1);
    status_body(n, 2);
    fend();
  endtask

  task automatic do_start(input logic [15:0] a16);
    fstart();
    sbyte(8'h25, 1);
    sbyte(a16[7:0], 1);
    if (!bus.core_busy) sq.push_back(a16);
    else err_m = 1'b1;
    sbyte(a16[15:8], 1);
    fend();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [15:0] a16;
    bus.frm_start = 1'b0;
    bus.frm_end   = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.tx_req    = 1'b0;
    bus.core_busy = 1'b0;
    bus.core_err  = 1'b0;
    probe_req     = 1'b0;
    err_m         = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    repeat (3) tick();
    probe(1, 1'b1, 1'b0);
    resetn = 1'b1;
    tick();
    probe(1, 1'b1, 1'b0);

    do_write(10, 1'b1, 2, 2);
    probe(0, 1'b1, 1'b0);
    do_read(16'h0000, 10, 1, 3);
    repeat (4) begin
      cnt = $urandom_range(3, 0);
      a16 = {8'($urandom) & 8'hFC, 8'($urandom_range(10 - cnt, 0))};
      do_read(a16, cnt, 1, 2);
    end
    do_read(16'h0003, 0, 2, 1);

    do_write(3, 1'b0, 0, 1);
    do_read(16'h0000, 3, 2, 0);

    do_start(16'h0000);
    bus.core_busy = 1'b1;
    tick();
    probe(0, 1'b0, 1'b0);
    do_status(3);
    bus.core_busy = 1'b0;
    tick();
    do_status(2);
    probe(0, 1'b1, 1'b0);
    do_start(16'($urandom));
    probe(0, 1'b1, 1'b0);

    fstart();
    sbyte(8'h7F, 1);
    repeat (3) sbyte(8'($urandom), 1);
    fend();
    err_m = 1'b1;
    probe(0, 1'b1, 1'b1);
    do_status(2);
    do_status(1);

    bus.core_busy = 1'b1;
    do_start(16'($urandom));
    probe(0, 1'b0, 1'b1);
    do_status(2);
    bus.core_busy = 1'b0;

    bus.core_err = 1'b1;
    err_m = 1'b1;
    tick();
    probe(0, 1'b1, 1'b1);
    do_status(2);
    bus.core_err = 1'b0;
    tick();
    do_status(2);

    fstart();
    sbyte(8'h21, 1);
    sbyte(8'($urandom), 1);
    sbyte(8'($urandom), 1);
    fstart();
    err_m = 1'b1;
    sbyte(8'h20, 1);
    status_body(2, 1);
    fend();

    fstart();
    sbyte(8'h21, 1);
    repeat (3) sbyte(8'($urandom), 1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'($urandom);
    bus.frm_end  = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.frm_end  = 1'b0;
    tick();
    probe(0, 1'b1, 1'b0);

    fstart();
    sbyte(8'h7F, 0);
    fend();
    err_m = 1'b1;
    probe(0, 1'b1, 1'b1);
    fstart();
    sbyte(8'h21, 1);
    sbyte(8'($urandom), 1);
    sbyte(8'($urandom), 1);
    #2;
    resetn = 1'b0;
    err_m  = 1'b0;
    probe(1, 1'b1, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    sbyte(8'($urandom), 0);
    sbyte(8'($urandom), 0);
    probe(0, 1'b1, 1'b0);
    do_status(1);

    do_write(DEPTH + 1, 1'b0, 0, 0);
    do_read(16'h0400, 2, 1, 1);

    probe(2, 1'b0, 1'b0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
